stream_mux_rr: RTL

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//
// Purpose:
//   Multiplexes N valid/ready input streams onto one registered output
//   stream. Each cycle at most one channel is granted, either the channel
//   named by 'sel' (fixed-select mode) or the next valid channel after the
//   last one served (round-robin mode). The output register takes a new beat
//   whenever it is empty or being drained on the same edge, so back-to-back
//   beats flow at one per cycle.
//
// Ports:
//   clk        - clock; all state changes on its rising edge
//   rst_n      - asynchronous active-low reset
//   in_data    - N*W bits, channel i in bits [i*W +: W]
//   in_valid   - per-channel beat offered
//   in_ready   - per-channel beat accepted (combinational, one-hot or zero)
//   force_en   - 1: fixed-select mode using 'sel'; 0: round-robin mode
//   sel        - channel index used in fixed-select mode
//   out_data   - registered output beat
//   out_ch     - source channel of out_data
//   out_valid  - out_data holds a beat
//   out_ready  - downstream accepts the beat
//   xfer_cnt   - count of accepted input beats, wraps at 16 bits
// ---------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           force_en,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [15:0]    xfer_cnt
);

    // Last channel served in round-robin mode; the search starts just after it.
    logic [SW-1:0] ptr;

    logic          slot_open;
    logic          sel_ok;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic          take;

    // Channel index 'step' positions after 'base', wrapping at N (N need not
    // be a power of two, so plain bit truncation is not enough).
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base,
                                               input int            step);
        return SW'((int'(base) + step) % N);
    endfunction

    // The output register can take a new beat if it is empty or its current
    // beat leaves on this same edge.
    assign slot_open = !out_valid || out_ready;

    // With a non-power-of-two N, sel can name a channel that does not exist.
    assign sel_ok = ({1'b0, sel} < (SW+1)'(N));

    // Round-robin search: first valid channel at ptr+1, ptr+2, ... mod N.
    // Ending at ptr itself lets a lone requester be granted every cycle.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_found && in_valid[wrap_idx(ptr, k)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_idx(ptr, k);
            end
        end
    end

    // Mode selection is purely combinational, so a change of force_en or sel
    // steers the very next grant.
    always_comb begin
        if (force_en) begin
            grant_valid = sel_ok && in_valid[sel];
            grant_idx   = sel;
        end else begin
            grant_valid = rr_found;
            grant_idx   = rr_idx;
        end
    end

    // in_ready is gated by rst_n so nothing is offered while in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && slot_open && grant_valid) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign take = |(in_valid & in_ready);

    // Output register, round-robin pointer and transfer counter. A new beat
    // takes priority over draining, which gives full throughput when both
    // happen on one edge. On a drain-only edge data and channel are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            xfer_cnt  <= '0;
            ptr       <= SW'(N - 1);
        end else begin
            if (take) begin
                out_data  <= in_data[int'(grant_idx)*W +: W];
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                xfer_cnt  <= xfer_cnt + 16'd1;
                if (!force_en) begin
                    ptr <= grant_idx;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
